jtag_scan_driver: RTL

Host-side JTAG scan engine that drives the TMS/TDI/TCK inputs of adder_with_TAP and captures its TDO. It sits directly upstream of the TAP-wrapped core. It accepts one IR or DR scan command at a time, walks the target TAP from Run-Test/Idle through Capture/Shift/Exit1/Update back to Run-Test/Idle, and returns the captured TDO bits. It also performs the TAP reset sequence automatically after reset.

---
 rtl/jtag_pkg.sv | 29 ++
 rtl/jtag_scan_driver.sv | 139 +++++++++++++
 2 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state encodings (common with TAP_Controller),
// the scan driver FSM encoding and the TAP reset sequence length.
package jtag_pkg;

  localparam logic [3:0] TAP_EXIT2_DR   = 4'h0;
  localparam logic [3:0] TAP_EXIT1_DR   = 4'h1;
  localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
  localparam logic [3:0] TAP_PAUSE_DR   = 4'h3;
  localparam logic [3:0] TAP_SELECT_IR  = 4'h4;
  localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
  localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
  localparam logic [3:0] TAP_SELECT_DR  = 4'h7;
  localparam logic [3:0] TAP_EXIT2_IR   = 4'h8;
  localparam logic [3:0] TAP_EXIT1_IR   = 4'h9;
  localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
  localparam logic [3:0] TAP_PAUSE_IR   = 4'hB;
  localparam logic [3:0] TAP_RTI        = 4'hC;
  localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;
  localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
  localparam logic [3:0] TAP_TLR        = 4'hF;

  // Driver states mirror the target TAP state after the most recent TCK rising edge.
  typedef enum logic [2:0] {
    RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } drv_state_t;

  localparam int RST_TMS_CYCLES = 5;

endpackage

// File: rtl/jtag_scan_driver.sv
// Host-side JTAG scan engine: resets the target TAP, then runs one IR/DR scan per start
// strobe from Run-Test/Idle back to Run-Test/Idle, returning the captured TDO bits.
module jtag_scan_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               TCK,
  input  logic               reset_bar,
  input  logic               start,
  input  logic               sel_ir,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] data_in,
  output logic [MAX_LEN-1:0] data_out,
  output logic               busy,
  output logic               done,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  drv_state_t         state;
  logic               ir_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [MAX_LEN-1:0] sh_out;
  logic [MAX_LEN-1:0] bit_sel;
  logic               tms_r;
  logic               tdi_r;
  logic [LEN_W-1:0]   len_eff;
  logic               last;

  always_comb begin
    len_eff = len;
    if (len == '0 || len > LEN_MAX) len_eff = LEN_MAX;
  end

  assign last = (cnt == len_q - LEN_W'(1));

  // tms_r/tdi_r hold the pin values for the next rising edge; the falling-edge stage presents them.
  always_ff @(posedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      state    <= RST_SEQ;
      ir_q     <= 1'b0;
      len_q    <= LEN_MAX;
      cnt      <= '0;
      sh_out   <= '0;
      bit_sel  <= '0;
      data_out <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      tms_r    <= 1'b1;
      tdi_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RST_SEQ: begin
          cnt   <= cnt + LEN_W'(1);
          tms_r <= (cnt < LEN_W'(RST_TMS_CYCLES - 1));
          if (cnt == LEN_W'(RST_TMS_CYCLES)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            tms_r <= 1'b0;
          end
        end
        IDLE: begin
          if (busy) begin
            // Accept edge already set TMS=1; next edge picks Select-IR only for IR scans.
            state <= SEL_DR;
            tms_r <= ir_q;
          end else if (start) begin
            ir_q     <= sel_ir;
            len_q    <= len_eff;
            sh_out   <= data_in;
            data_out <= '0;
            busy     <= 1'b1;
            tms_r    <= 1'b1;
          end
        end
        SEL_DR: begin
          state <= ir_q ? SEL_IR : CAPTURE;
          tms_r <= 1'b0;
        end
        SEL_IR: begin
          state <= CAPTURE;
          tms_r <= 1'b0;
        end
        CAPTURE: begin
          state   <= SHIFT;
          cnt     <= '0;
          bit_sel <= MAX_LEN'(1);
          tms_r   <= (len_q == LEN_W'(1));
          tdi_r   <= sh_out[0];
          sh_out  <= sh_out >> 1;
        end
        SHIFT: begin
          if (TDO) data_out <= data_out | bit_sel;
          bit_sel <= bit_sel << 1;
          if (last) begin
            state <= EXIT1;
            tms_r <= 1'b1;
            tdi_r <= 1'b0;
          end else begin
            cnt    <= cnt + LEN_W'(1);
            tms_r  <= (cnt + LEN_W'(2) == len_q);
            tdi_r  <= sh_out[0];
            sh_out <= sh_out >> 1;
          end
        end
        EXIT1: begin
          state <= UPDATE;
          tms_r <= 1'b0;
        end
        UPDATE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          tms_r <= 1'b0;
        end
        default: state <= RST_SEQ;
      endcase
    end
  end

  always_ff @(negedge TCK or negedge reset_bar) begin
    if (!reset_bar) begin
      TMS <= 1'b1;
      TDI <= 1'b0;
    end else begin
      TMS <= tms_r;
      TDI <= tdi_r;
    end
  end

endmodule
